// File: rtl/pacman_pkg.sv
// Shared encodings and timing constants for the maze game logic.
package pacman_pkg;

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'b00,
    MODE_CHASE   = 2'b01,
    MODE_FRIGHT  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    BLINKY = 2'd0,
    PINKY  = 2'd1,
    INKY   = 2'd2,
    CLYDE  = 2'd3
  } ghost_e;

  // 25 MHz system clock divided down to the 60 Hz game tick
  localparam int TICK_DIV_60HZ = 416_666;

endpackage

// File: rtl/game_tick_gen.sv
// Free-running divider producing a one-cycle strobe every TICK_DIV+1 clocks.
module game_tick_gen #(
  parameter int TICK_DIV = pacman_pkg::TICK_DIV_60HZ
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);

  logic [W-1:0] tickDiv;

  assign tick = (tickDiv == W'(TICK_DIV));

  always_ff @(posedge clk) begin
    if (reset)     tickDiv <= '0;
    else if (tick) tickDiv <= '0;
    else           tickDiv <= tickDiv + W'(1);
  end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost controller: scatter/chase phase table, frightened timer and
// ghost-house release sequencing, all advancing on the 60 Hz game tick.
module ghost_mode_scheduler
  import pacman_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_60HZ,
  parameter int SCATTER_A    = 420,
  parameter int SCATTER_B    = 300,
  parameter int CHASE_T      = 1200,
  parameter int FRIGHT_TICKS = 360,
  parameter int FLASH_TICKS  = 120,
  parameter int INKY_DOTS    = 30,
  parameter int CLYDE_DOTS   = 60,
  parameter int IDLE_TICKS   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze,
  input  logic       dotEaten,
  input  logic       powerEaten,
  output logic [1:0] mode,
  output logic       frightFlash,
  output logic       reverseReq,
  output logic [3:0] ghostRelease,
  output logic [2:0] phaseIdx
);

  localparam int PHASE_MAX = (CHASE_T > SCATTER_A) ?
                             ((CHASE_T > SCATTER_B) ? CHASE_T : SCATTER_B) :
                             ((SCATTER_A > SCATTER_B) ? SCATTER_A : SCATTER_B);
  localparam int PC_W = $clog2(PHASE_MAX + 1);
  localparam int FT_RAW = $clog2(FRIGHT_TICKS + 1);
  localparam int FT_W = (FT_RAW < 4) ? 4 : FT_RAW;
  localparam int IC_W = (IDLE_TICKS < 2) ? 1 : $clog2(IDLE_TICKS);

  logic            tick, advance;
  logic [PC_W-1:0] phaseCnt, phaseCntNext;
  logic [2:0]      phaseIdxNext;
  logic            phaseExpire;
  logic [FT_W-1:0] frightTimer, frightNext;
  logic            frightEntry, flashNext;
  mode_e           modeNext;
  logic [2:0]      waitIdx, waitIdxNext;
  logic [6:0]      dotCnt, dotCntNext;
  logic [IC_W-1:0] idleCnt, idleCntNext;
  logic [3:0]      relNext;
  logic            relFire;

  function automatic logic [PC_W-1:0] phaseDur(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd2: phaseDur = PC_W'(SCATTER_A);
      3'd4, 3'd6: phaseDur = PC_W'(SCATTER_B);
      default:    phaseDur = PC_W'(CHASE_T);
    endcase
  endfunction

  function automatic logic [6:0] relThr(input logic [2:0] idx);
    case (idx)
      3'd1:    relThr = 7'd0;
      3'd2:    relThr = 7'(INKY_DOTS);
      default: relThr = 7'(CLYDE_DOTS);
    endcase
  endfunction

  game_tick_gen #(.TICK_DIV(TICK_DIV)) uTick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign advance = tick && !freeze;

  always_comb begin
    phaseIdxNext = phaseIdx;
    phaseCntNext = phaseCnt;
    phaseExpire  = 1'b0;
    // phase table pauses while frightened; the last phase is endless chase
    if (advance && frightTimer == '0 && phaseIdx != 3'd7) begin
      if (phaseCnt == phaseDur(phaseIdx) - PC_W'(1)) begin
        phaseIdxNext = phaseIdx + 3'd1;
        phaseCntNext = '0;
        phaseExpire  = 1'b1;
      end else begin
        phaseCntNext = phaseCnt + PC_W'(1);
      end
    end

    frightNext = frightTimer;
    if (powerEaten)                         frightNext = FT_W'(FRIGHT_TICKS);
    else if (advance && frightTimer != '0)  frightNext = frightTimer - FT_W'(1);
    frightEntry = powerEaten && (frightTimer == '0);

    modeNext  = (frightNext != '0) ? MODE_FRIGHT :
                (phaseIdxNext[0] ? MODE_CHASE : MODE_SCATTER);
    flashNext = (frightTimer != '0) && (frightTimer <= FT_W'(FLASH_TICKS)) && frightTimer[3];

    relFire = (waitIdx < 3'd4) &&
              ((dotCnt >= relThr(waitIdx)) ||
               (advance && idleCnt == IC_W'(IDLE_TICKS - 1)));
    relNext     = ghostRelease;
    waitIdxNext = waitIdx;
    dotCntNext  = dotCnt;
    idleCntNext = idleCnt;
    if (relFire) begin
      relNext[waitIdx[1:0]] = 1'b1;
      waitIdxNext = waitIdx + 3'd1;
      dotCntNext  = '0;
      idleCntNext = '0;
    end else begin
      if (dotEaten && dotCnt != 7'h7F) dotCntNext = dotCnt + 7'd1;
      if (dotEaten)                    idleCntNext = '0;
      else if (advance && idleCnt != IC_W'(IDLE_TICKS - 1))
                                       idleCntNext = idleCnt + IC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phaseIdx     <= 3'd0;
      phaseCnt     <= '0;
      frightTimer  <= '0;
      mode         <= MODE_SCATTER;
      frightFlash  <= 1'b0;
      reverseReq   <= 1'b0;
      ghostRelease <= 4'b0001;
      waitIdx      <= 3'd1;
      dotCnt       <= '0;
      idleCnt      <= '0;
    end else begin
      phaseIdx     <= phaseIdxNext;
      phaseCnt     <= phaseCntNext;
      frightTimer  <= frightNext;
      mode         <= modeNext;
      frightFlash  <= flashNext;
      reverseReq   <= phaseExpire || frightEntry;
      ghostRelease <= relNext;
      waitIdx      <= waitIdxNext;
      dotCnt       <= dotCntNext;
      idleCnt      <= idleCntNext;
    end
  end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler with a 10-clock game tick.
module tb_ghost_mode_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       freeze = 1'b0;
  logic       dotEaten = 1'b0;
  logic       powerEaten = 1'b0;
  logic [1:0] mode;
  logic       frightFlash;
  logic       reverseReq;
  logic [3:0] ghostRelease;
  logic [2:0] phaseIdx;

  int errors = 0;
  int nChecks = 0;
  int edgeCnt = 0;

  always #5 clk = ~clk;

  ghost_mode_scheduler #(
    .TICK_DIV(9), .SCATTER_A(5), .SCATTER_B(4), .CHASE_T(8),
    .FRIGHT_TICKS(20), .FLASH_TICKS(8), .INKY_DOTS(3), .CLYDE_DOTS(4),
    .IDLE_TICKS(6)
  ) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .dotEaten(dotEaten),
    .powerEaten(powerEaten), .mode(mode), .frightFlash(frightFlash),
    .reverseReq(reverseReq), .ghostRelease(ghostRelease), .phaseIdx(phaseIdx)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (edge %0d): observed=%0h expected=%0h", tag, edgeCnt, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edgeCnt++;
    #1;
  endtask

  task automatic stepTo(input int e);
    while (edgeCnt < e) step();
  endtask

  task automatic checkReset(input string tag);
    check({tag, ".mode"},  8'(mode), 8'h0);
    check({tag, ".flash"}, 8'(frightFlash), 8'h0);
    check({tag, ".rev"},   8'(reverseReq), 8'h0);
    check({tag, ".rel"},   8'(ghostRelease), 8'h1);
    check({tag, ".phase"}, 8'(phaseIdx), 8'h0);
  endtask

  task automatic doReset();
    reset = 1'b1; freeze = 1'b0; dotEaten = 1'b0; powerEaten = 1'b0;
    step(); step();
    checkReset("rst");
    reset = 1'b0;
    edgeCnt = 0;
  endtask

  initial begin
    // plain run: Pinky at once, phase 0 -> 1 at tick 5, idle releases at ticks 6 and 12
    doReset();
    step();
    check("t1.pinky", 8'(ghostRelease), 8'h3);
    check("t1.mode0", 8'(mode), 8'h0);
    stepTo(49);
    check("t1.phasePre", 8'(phaseIdx), 8'h0);
    check("t1.revPre", 8'(reverseReq), 8'h0);
    stepTo(50);
    check("t1.phase1", 8'(phaseIdx), 8'h1);
    check("t1.chase", 8'(mode), 8'h1);
    check("t1.rev", 8'(reverseReq), 8'h1);
    step();
    check("t1.revOnce", 8'(reverseReq), 8'h0);
    stepTo(59);
    check("t5.idlePre", 8'(ghostRelease), 8'h3);
    stepTo(60);
    check("t5.inkyIdle", 8'(ghostRelease), 8'h7);
    stepTo(119);
    check("t5.clydePre", 8'(ghostRelease), 8'h7);
    stepTo(120);
    check("t5.clydeIdle", 8'(ghostRelease), 8'hF);
    stepTo(130);
    check("t1.phase2", 8'(phaseIdx), 8'h2);
    check("t1.scatter2", 8'(mode), 8'h0);
    check("t1.rev2", 8'(reverseReq), 8'h1);

    // power pellet at tick 2: frightened for 20 ticks, flash only at timer 8
    doReset();
    stepTo(20);
    powerEaten = 1'b1;
    step();
    powerEaten = 1'b0;
    check("t2.fright", 8'(mode), 8'h2);
    check("t2.revEntry", 8'(reverseReq), 8'h1);
    step();
    check("t2.revOnce", 8'(reverseReq), 8'h0);
    stepTo(140);
    check("t2.flash9", 8'(frightFlash), 8'h0);
    stepTo(141);
    check("t2.flash8", 8'(frightFlash), 8'h1);
    stepTo(150);
    check("t2.flash8end", 8'(frightFlash), 8'h1);
    stepTo(151);
    check("t2.flash7", 8'(frightFlash), 8'h0);
    stepTo(211);
    check("t2.flash1", 8'(frightFlash), 8'h0);
    stepTo(219);
    check("t2.frightLast", 8'(mode), 8'h2);
    stepTo(220);
    check("t2.exitMode", 8'(mode), 8'h0);
    check("t2.exitNoRev", 8'(reverseReq), 8'h0);
    check("t2.phaseHeld", 8'(phaseIdx), 8'h0);
    stepTo(249);
    check("t2.phaseLatePre", 8'(phaseIdx), 8'h0);
    stepTo(250);
    check("t2.phaseLate", 8'(phaseIdx), 8'h1);
    check("t2.phaseLateRev", 8'(reverseReq), 8'h1);

    // second pellet at timer 4 restarts fright without a reverse
    doReset();
    stepTo(20);
    powerEaten = 1'b1;
    step();
    powerEaten = 1'b0;
    stepTo(180);
    powerEaten = 1'b1;
    step();
    powerEaten = 1'b0;
    check("t3.mode", 8'(mode), 8'h2);
    check("t3.noRev", 8'(reverseReq), 8'h0);
    check("t3.flash4", 8'(frightFlash), 8'h0);
    stepTo(182);
    check("t3.flash20", 8'(frightFlash), 8'h0);
    stepTo(225);
    check("t3.stillFright", 8'(mode), 8'h2);
    stepTo(379);
    check("t3.frightLast", 8'(mode), 8'h2);
    stepTo(380);
    check("t3.exit", 8'(mode), 8'h0);
    check("t3.exitNoRev", 8'(reverseReq), 8'h0);

    // dot-driven releases
    doReset();
    step();
    dotEaten = 1'b1;
    step(); step(); step();
    dotEaten = 1'b0;
    check("t4.inkyPre", 8'(ghostRelease), 8'h3);
    step();
    check("t4.inky", 8'(ghostRelease), 8'h7);
    dotEaten = 1'b1;
    step(); step(); step(); step();
    dotEaten = 1'b0;
    check("t4.clydePre", 8'(ghostRelease), 8'h7);
    step();
    check("t4.clyde", 8'(ghostRelease), 8'hF);
    dotEaten = 1'b1;
    for (int i = 0; i < 10; i++) step();
    dotEaten = 1'b0;
    check("t4.extraDots", 8'(ghostRelease), 8'hF);

    // freeze for 30 ticks mid-scatter, then reset while frightened
    doReset();
    stepTo(20);
    freeze = 1'b1;
    stepTo(310);
    check("t6.frzPhase", 8'(phaseIdx), 8'h0);
    check("t6.frzMode", 8'(mode), 8'h0);
    check("t6.frzRel", 8'(ghostRelease), 8'h3);
    stepTo(320);
    freeze = 1'b0;
    stepTo(349);
    check("t6.phasePre", 8'(phaseIdx), 8'h0);
    stepTo(350);
    check("t6.phase1", 8'(phaseIdx), 8'h1);
    stepTo(359);
    check("t6.inkyPre", 8'(ghostRelease), 8'h3);
    stepTo(360);
    check("t6.inky", 8'(ghostRelease), 8'h7);
    freeze = 1'b1;
    powerEaten = 1'b1;
    step();
    powerEaten = 1'b0;
    check("t6.frzPower", 8'(mode), 8'h2);
    check("t6.frzPowerRev", 8'(reverseReq), 8'h1);
    for (int i = 0; i < 250; i++) step();
    check("t6.frzFrightHeld", 8'(mode), 8'h2);
    reset = 1'b1;
    powerEaten = 1'b1;
    dotEaten = 1'b1;
    step();
    checkReset("t6.midReset");
    reset = 1'b0;
    powerEaten = 1'b0;
    dotEaten = 1'b0;
    freeze = 1'b0;
    step();
    check("t6.pinkyAgain", 8'(ghostRelease), 8'h3);
    check("t6.modeAgain", 8'(mode), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, nChecks);
    $finish;
  end

endmodule

// File: doc/ghost_mode_scheduler.md
Name: ghost_mode_scheduler

Overview:
- Global ghost controller. Sequences the level-wide scatter/chase phase table, frightened mode, and ghost-house releases.
- Sits between the game-state logic (dot/power-pellet events, death freeze) and the four ghost movers.
- The ghost movers take `mode`, `reverseReq` and their `ghostRelease` bit, then pick targets and leave the house accordingly.
- All outputs are registered and advance on an internal 60 Hz game tick.

Parameters:
- TICK_DIV, 416_666: clk cycles per game tick, minus 1 (25 MHz to 60 Hz).
- SCATTER_A, 420: ticks for scatter phases 0 and 2 (7 s).
- SCATTER_B, 300: ticks for scatter phases 4 and 6 (5 s).
- CHASE_T, 1200: ticks for chase phases 1, 3 and 5 (20 s). Phase 7 is chase with no end.
- FRIGHT_TICKS, 360: frightened duration (6 s).
- FLASH_TICKS, 120: final part of frightened time during which the flash output is active.
- INKY_DOTS, 30: dots required to release Inky.
- CLYDE_DOTS, 60: dots required to release Clyde.
- IDLE_TICKS, 240: ticks with no dot eaten that force release of the next waiting ghost.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- freeze  in  1  death/intermission; holds all tick-driven timers
- dotEaten  in  1  one-cycle pulse per small dot
- powerEaten  in  1  one-cycle pulse per power pellet
- mode  out  2  00 = scatter, 01 = chase, 10 = frightened
- frightFlash  out  1  high while the frightened-ending flash is shown
- reverseReq  out  1  one-cycle pulse; all ghosts reverse direction
- ghostRelease  out  4  sticky release bits: [0] Blinky, [1] Pinky, [2] Inky, [3] Clyde
- phaseIdx  out  3  current scatter/chase phase, 0..7

Behaviour:
- Reset values: `mode` = 00, `frightFlash` = 0, `reverseReq` = 0, `ghostRelease` = 4'b0001, `phaseIdx` = 0. All counters are cleared; tickDiv = 0.
- Reset asserted mid-operation restores all of the above on the next clock edge, regardless of other inputs.
- Tick generation:
  - tickDiv counts 0..TICK_DIV and wraps.
  - `tick` is a one-cycle internal strobe at the wrap.
  - The divider free-runs even when `freeze` is high.
  - "Advance" means `tick && !freeze`.
- Phase timer (phaseCnt):
  - Increments on advance only while frightTimer == 0; it is paused during frightened time.
  - At advance with phaseCnt == duration(phaseIdx) − 1: `phaseIdx` increments, phaseCnt clears, and `reverseReq` pulses the next cycle.
  - Phase 7 never expires.
  - Even phase index means scatter; odd means chase.
- Frightened:
  - `powerEaten` loads frightTimer = FRIGHT_TICKS. This applies even if frightened is already active (restart), and even when `freeze` is high.
  - frightTimer decrements on advance while nonzero.
  - `mode` = 10 while frightTimer != 0; otherwise it follows the phase parity.
  - `reverseReq` pulses on entry into frightened (0 to nonzero), but not on a restart and not on exit.
  - If a phase expiry and `powerEaten` occur in the same cycle, only one `reverseReq` pulse is issued.
- Flash: `frightFlash` = (frightTimer != 0) && (frightTimer <= FLASH_TICKS) && frightTimer[3]. It is registered and updates one cycle after frightTimer.
- Release sequencer:
  - waitIdx starts at 1 (Pinky), uses a dotCnt of 7 bits and an idleCnt.
  - Thresholds: Pinky 0, Inky INKY_DOTS, Clyde CLYDE_DOTS.
  - `dotEaten` increments dotCnt and clears idleCnt.
  - idleCnt increments on advance when no dot arrives that cycle.
  - Release fires when dotCnt >= threshold(waitIdx) or idleCnt == IDLE_TICKS − 1 at an advance.
  - On release: set `ghostRelease[waitIdx]`, waitIdx++, clear dotCnt and idleCnt. At most one release per cycle.
  - Pinky is therefore released on the first cycle after reset deasserts.
  - After waitIdx reaches 4, the sequencer is idle and dotCnt saturates.
- Simultaneous `dotEaten` and `powerEaten`: both take effect.
- Freeze: phase, fright and idle counters hold. `dotEaten` and `powerEaten` still register.
- All internal arithmetic is unsigned. Counter widths are sized for the parameter maxima and must never wrap.

Decomposition:
- Shared package `pacman_pkg`:
  - mode encodings MODE_SCATTER, MODE_CHASE, MODE_FRIGHT.
  - direction encodings UP=00, RIGHT=01, DOWN=10, LEFT=11.
  - ghost indices BLINKY..CLYDE.
  - TICK_DIV for 60 Hz.
- Sub-module `game_tick_gen`: parameterised divider emitting a one-cycle tick. It replaces the per-ghost copies of the same divider.

Test Plan (bench uses TICK_DIV = 9, SCATTER_A = 5, CHASE_T = 8, FRIGHT_TICKS = 20, FLASH_TICKS = 8, IDLE_TICKS = 6, INKY_DOTS = 3, CLYDE_DOTS = 4):
1. Reset then run 50 cycles → `ghostRelease` = 0011 one cycle after reset falls; `mode` = 00; at tick 5 `phaseIdx` goes 0 to 1, `mode` = 01, one `reverseReq` pulse.
2. `powerEaten` at tick 2 → `mode` = 10 next cycle with one `reverseReq`. `phaseIdx` transition delayed by 20 ticks. `frightFlash` high for frightTimer = 8 only (bit 3 set) and low for 7..1. `mode` returns to 00 without a reverse.
3. Second `powerEaten` at frightTimer = 4 → timer reloads to 20; no `reverseReq`; `frightFlash` low.
4. Three `dotEaten` pulses → `ghostRelease` = 0111; four more → 1111; further dots cause no change.
5. No dots for 6 ticks after Pinky release → Inky released; 6 more ticks → Clyde released.
6. `freeze` high for 30 ticks mid-scatter → `phaseIdx`, `mode` and releases unchanged. Assert `reset` while frightened → all outputs return to reset values the next edge.
